// File: rtl/counters_pkg.sv
// counters_pkg
// Shared constants for the counter stage and its event logger: the
// bit positions of a logged event record, the packing of the host status
// word, and the index of each threshold flag inside the event mask.
// No ports; imported by the logger and its FIFO.
package counters_pkg;

    // Event record layout (32 bits)
    localparam int REC_MASK_MSB = 31;
    localparam int REC_MASK_LSB = 29;
    localparam int REC_LOST     = 28;
    localparam int REC_TS_MSB   = 27;
    localparam int REC_TS_LSB   = 16;
    localparam int REC_C2       = 8;   // LSB of the 8-bit count2 field
    localparam int REC_C1       = 0;   // LSB of the 8-bit count1 field

    // Status word layout (32 bits)
    localparam int ST_DROP_LSB  = 24;
    localparam int ST_LOST      = 23;
    localparam int ST_FULL      = 17;
    localparam int ST_EMPTY     = 16;
    localparam int ST_LEVEL_LSB = 0;

    // Event-mask bit indices
    localparam int EV_C1_00 = 0;
    localparam int EV_C1_80 = 1;
    localparam int EV_C2_FF = 2;
    localparam int NUM_EV   = 3;

    typedef logic [31:0] record_t;

    function automatic record_t pack_record(
        input logic [NUM_EV-1:0] mask,
        input logic              lost,
        input logic [11:0]       ts,
        input logic [7:0]        c2,
        input logic [7:0]        c1
    );
        record_t r;
        r = '0;
        r[REC_MASK_MSB:REC_MASK_LSB] = mask;
        r[REC_LOST]                  = lost;
        r[REC_TS_MSB:REC_TS_LSB]     = ts;
        r[REC_C2 +: 8]               = c2;
        r[REC_C1 +: 8]               = c1;
        return r;
    endfunction

endpackage

// File: rtl/counter_event_logger_if.sv
// counter_event_logger_if
// Host-side endpoint bundle of the event logger (okWireOut/okTriggerIn
// style access).
//   clear         host -> logger  one-cycle flush pulse
//   pop           host -> logger  one-cycle discard-head pulse
//   rd_data       logger -> host  head record, 0 when empty
//   status        logger -> host  drop count / lost / full / empty / level
//   nonempty_trig logger -> host  one-cycle empty->non-empty pulse
interface counter_event_logger_if;
    logic        clear;
    logic        pop;
    logic [31:0] rd_data;
    logic [31:0] status;
    logic        nonempty_trig;

    modport master (
        output clear,
        output pop,
        input  rd_data,
        input  status,
        input  nonempty_trig
    );

    modport slave (
        input  clear,
        input  pop,
        output rd_data,
        output status,
        output nonempty_trig
    );
endinterface

// File: rtl/event_fifo.sv
// event_fifo
// Synchronous show-ahead FIFO of 32-bit event records.
//   sys_clk  in   clock
//   reset_n  in   synchronous active-low reset
//   push     in   write din this cycle
//   pop      in   discard head this cycle (ignored when empty)
//   clear    in   flush; overrides push and pop
//   din      in   record to write
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   level    out  number of entries held
//   head     out  oldest entry (undefined when empty)
module event_fifo import counters_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  record_t                    din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output record_t                    head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    record_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign level = wr_ptr - rd_ptr;
    // Level never exceeds DEPTH, and DEPTH is a power of two, so the
    // top level bit alone marks full.
    assign full  = level[AW];
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop on a full FIFO frees a slot for a push in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear && (!full || do_pop);

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset_n && do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/counter_event_logger.sv
// counter_event_logger
// Detects rising edges of the counter threshold flags, stamps each event
// with both counter values and a tick timestamp, and queues the records
// for the host to drain one word at a time.
//   sys_clk     in   clock
//   reset_n     in   synchronous active-low reset
//   enable      in   gates event capture and timestamp advance
//   tick        in   timestamp advance strobe
//   count1/2    in   counter values captured into each record
//   count1eq00, count1eq80, count2eqFF  in  threshold level flags
//   host        slave side of counter_event_logger_if
module counter_event_logger import counters_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 12
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    tick,
    input  logic [7:0]              count1,
    input  logic [7:0]              count2,
    input  logic                    count1eq00,
    input  logic                    count1eq80,
    input  logic                    count2eqFF,
    counter_event_logger_if.slave   host
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [NUM_EV-1:0] flags;
    logic [NUM_EV-1:0] prev;
    logic [NUM_EV-1:0] mask;
    logic              ev;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;
    logic [TS_W-1:0]   ts;
    logic [7:0]        drop_cnt;
    logic              lost_pending;
    logic              trig_q;
    record_t           record;
    record_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;

    always_comb begin
        flags           = '0;
        flags[EV_C1_00] = count1eq00;
        flags[EV_C1_80] = count1eq80;
        flags[EV_C2_FF] = count2eqFF;
    end

    assign mask    = flags & ~prev;
    assign ev      = enable && (mask != '0);
    assign pop_ok  = host.pop && !fifo_empty;
    assign push_ok = ev && !host.clear && (!fifo_full || pop_ok);
    assign drop    = ev && !host.clear && fifo_full && !pop_ok;
    assign record  = pack_record(mask, lost_pending, ts, count2, count1);

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (host.pop),
        .clear   (host.clear),
        .din     (record),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .head    (head)
    );

    // prev resets to all ones so flags already high out of reset stay
    // silent, and it tracks the flags even while capture is disabled.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            prev         <= '1;
            ts           <= '0;
            drop_cnt     <= '0;
            lost_pending <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            prev   <= flags;
            // Only a push into an empty FIFO can create the transition,
            // and the FIFO is non-empty the cycle after, so no back-to-back.
            trig_q <= push_ok && fifo_empty;
            if (host.clear) begin
                ts           <= '0;
                drop_cnt     <= '0;
                lost_pending <= 1'b0;
            end else begin
                if (tick && enable) ts <= ts + TS_W'(1);
                if (push_ok) begin
                    lost_pending <= 1'b0;
                end else if (drop) begin
                    lost_pending <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        host.status                            = '0;
        host.status[ST_DROP_LSB +: 8]          = drop_cnt;
        host.status[ST_LOST]                   = lost_pending;
        host.status[ST_FULL]                   = fifo_full;
        host.status[ST_EMPTY]                  = fifo_empty;
        host.status[ST_LEVEL_LSB +: LVL_W]     = fifo_level;
    end

    assign host.rd_data       = fifo_empty ? '0 : head;
    assign host.nonempty_trig = trig_q;

endmodule

// File: tb/tb_counter_event_logger.sv
module tb_counter_event_logger;

    localparam int DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       tick;
    logic [7:0] count1;
    logic [7:0] count2;
    logic       f00;
    logic       f80;
    logic       fff;

    counter_event_logger_if bus();

    counter_event_logger #(.DEPTH(DEPTH), .TS_W(12)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick),
        .count1     (count1),
        .count2     (count2),
        .count1eq00 (f00),
        .count1eq80 (f80),
        .count2eqFF (fff),
        .host       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a queue of records plus the bookkeeping scalars.
    logic [31:0] m_q[$];
    logic [2:0]  m_prev;
    int          m_ts;
    int          m_drop;
    bit          m_lost;
    bit          m_trig;

    typedef struct {
        logic        en;
        logic        tk;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [2:0]  fl;    // {count2eqFF, count1eq80, count1eq00}
        logic        clr;
        logic        pp;
        logic [31:0] rd;
        logic [31:0] st;
        logic        trig;
    } vec_t;

    vec_t tbl[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_in(input logic en, input logic tk, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [2:0] fl,
                          input logic clr, input logic pp);
        enable    = en;
        tick      = tk;
        count1    = c1;
        count2    = c2;
        {fff, f80, f00} = fl;
        bus.clear = clr;
        bus.pop   = pp;
    endtask

    task automatic model_update();
        logic [2:0] fl;
        logic [2:0] rise;
        bit         was_empty;
        fl = {fff, f80, f00};
        m_trig = 0;
        if (!reset_n) begin
            m_q.delete();
            m_prev = 3'b111;
            m_ts   = 0;
            m_drop = 0;
            m_lost = 0;
            return;
        end
        rise   = fl & ~m_prev;
        m_prev = fl;
        if (bus.clear) begin
            m_q.delete();
            m_ts   = 0;
            m_drop = 0;
            m_lost = 0;
        end else begin
            was_empty = (m_q.size() == 0);
            if (bus.pop && !was_empty) void'(m_q.pop_front());
            if (enable && rise != 3'b000) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({rise, m_lost, 12'(m_ts), count2, count1});
                    m_lost = 0;
                    m_trig = was_empty;
                end else begin
                    if (m_drop < 255) m_drop++;
                    m_lost = 1;
                end
            end
            if (enable && tick) m_ts = (m_ts + 1) % 4096;
        end
    endtask

    function automatic logic [31:0] exp_rd();
        return (m_q.size() != 0) ? m_q[0] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_status();
        int n;
        n = m_q.size();
        return {m_drop[7:0], m_lost, 5'b0, (n == DEPTH), (n == 0), 16'(n)};
    endfunction

    // Model sees the same inputs the DUT samples at the next edge.
    task automatic step(input bit cmp);
        model_update();
        @(posedge sys_clk);
        #1;
        if (cmp) begin
            check32("model_rd_data", bus.rd_data, exp_rd());
            check32("model_status", bus.status, exp_status());
            check32("model_trig", {31'b0, bus.nonempty_trig}, {31'b0, m_trig});
        end
    endtask

    initial begin
        // Reset with count1eq00 already high: must not log anything.
        reset_n = 1'b0;
        set_in(1, 0, 8'h00, 8'h00, 3'b001, 0, 0);
        repeat (3) step(1);
        check32("reset_rd_data", bus.rd_data, 32'h0);
        check32("reset_status", bus.status, 32'h0001_0000);
        check32("reset_trig", {31'b0, bus.nonempty_trig}, 32'h0);
        reset_n = 1'b1;

        // en tk c1 c2 fl clr pop | rd st trig
        tbl.push_back('{1, 0, 8'h00, 8'h00, 3'b001, 0, 0, 32'h0, 32'h0001_0000, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1, 1, 8'h00, 8'h00, 3'b001, 0, 0, 32'h0, 32'h0001_0000, 0});
        tbl.push_back('{1, 0, 8'h80, 8'h12, 3'b010, 0, 0, 32'h4005_1280, 32'h0000_0001, 1});
        tbl.push_back('{1, 0, 8'h80, 8'h12, 3'b010, 0, 0, 32'h4005_1280, 32'h0000_0001, 0});
        tbl.push_back('{1, 0, 8'h80, 8'h12, 3'b010, 0, 1, 32'h0, 32'h0001_0000, 0});
        tbl.push_back('{1, 0, 8'h80, 8'h12, 3'b010, 0, 1, 32'h0, 32'h0001_0000, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 3'b001, 0, 0, 32'h0, 32'h0001_0000, 0});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 3'b001, 0, 0, 32'h0, 32'h0001_0000, 0});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 3'b011, 0, 0, 32'h4005_0000, 32'h0000_0001, 1});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 3'b011, 0, 1, 32'h0, 32'h0001_0000, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].en, tbl[i].tk, tbl[i].c1, tbl[i].c2, tbl[i].fl, tbl[i].clr, tbl[i].pp);
            step(1);
            check32($sformatf("tbl%0d_rd_data", i), bus.rd_data, tbl[i].rd);
            check32($sformatf("tbl%0d_status", i), bus.status, tbl[i].st);
            check32($sformatf("tbl%0d_trig", i), {31'b0, bus.nonempty_trig}, {31'b0, tbl[i].trig});
        end

        // Timestamp wrap: 5 + 4090 ticks reaches 0xFFF.
        set_in(1, 1, 8'h00, 8'h00, 3'b000, 0, 0);
        repeat (4090) step(1);
        set_in(1, 1, 8'h00, 8'hFF, 3'b101, 0, 0);
        step(1);
        check32("wrap_rec", bus.rd_data, 32'hAFFF_FF00);
        check32("wrap_trig", {31'b0, bus.nonempty_trig}, 32'h1);
        set_in(1, 0, 8'h00, 8'h00, 3'b000, 0, 0);
        step(1);
        check32("wrap_trig_once", {31'b0, bus.nonempty_trig}, 32'h0);
        set_in(1, 0, 8'h80, 8'h00, 3'b010, 0, 0);
        step(1);
        set_in(1, 0, 8'h80, 8'h00, 3'b010, 0, 1);
        step(1);
        check32("wrap_ts_zero", bus.rd_data, 32'h4000_0080);
        step(1);

        // Fill, overflow by three, recover with the lost flag.
        set_in(1, 0, 8'h00, 8'h00, 3'b000, 1, 0);
        step(1);
        for (int k = 0; k < 19; k++) begin
            set_in(1, 0, 8'(k), 8'h00, (k % 2) ? 3'b010 : 3'b001, 0, 0);
            step(1);
        end
        check32("overflow_status", bus.status, 32'h0382_0010);
        set_in(1, 0, 8'h00, 8'h00, 3'b001, 0, 1);
        step(1);
        check32("pop_full_status", bus.status, 32'h0380_000F);
        set_in(1, 0, 8'h55, 8'h00, 3'b010, 0, 0);
        step(1);
        check32("lost_clears_status", bus.status, 32'h0302_0010);
        set_in(1, 0, 8'h66, 8'h00, 3'b001, 0, 1);
        step(1);
        check32("full_pop_push_status", bus.status, 32'h0302_0010);
        for (int i = 0; i < 16; i++) begin
            check32($sformatf("drain%0d_lost_bit", i), {31'b0, bus.rd_data[28]},
                    (i == 14) ? 32'h1 : 32'h0);
            set_in(1, 0, 8'h00, 8'h00, 3'b001, 0, 1);
            step(1);
        end
        check32("drained_status", bus.status, 32'h0301_0000);
        step(1);
        check32("pop_empty_status", bus.status, 32'h0301_0000);

        // Clear together with an event while five records are queued.
        set_in(1, 0, 8'h00, 8'h00, 3'b000, 1, 0);
        step(1);
        check32("clear_status", bus.status, 32'h0001_0000);
        set_in(1, 1, 8'h00, 8'h00, 3'b000, 0, 0);
        repeat (3) step(1);
        for (int k = 0; k < 5; k++) begin
            set_in(1, 0, 8'(k), 8'h00, (k % 2) ? 3'b010 : 3'b001, 0, 0);
            step(1);
        end
        check32("five_status", bus.status, 32'h0000_0005);
        set_in(1, 0, 8'h00, 8'h00, 3'b010, 1, 0);
        step(1);
        check32("clear_event_status", bus.status, 32'h0001_0000);
        check32("clear_event_rd", bus.rd_data, 32'h0);
        set_in(1, 0, 8'h00, 8'h00, 3'b000, 0, 0);
        step(1);
        set_in(1, 0, 8'h11, 8'hFF, 3'b100, 0, 0);
        step(1);
        check32("clear_ts_zero", bus.rd_data, 32'h8000_FF11);

        // Reset mid-operation.
        reset_n = 1'b0;
        step(1);
        check32("midreset_status", bus.status, 32'h0001_0000);
        check32("midreset_rd", bus.rd_data, 32'h0);
        reset_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 499) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            tick      = $urandom_range(0, 1) != 0;
            count1    = 8'($urandom_range(0, 255));
            count2    = 8'($urandom_range(0, 255));
            f00       = f00 ^ ($urandom_range(0, 2) == 0);
            f80       = f80 ^ ($urandom_range(0, 2) == 0);
            fff       = fff ^ ($urandom_range(0, 2) == 0);
            bus.clear = ($urandom_range(0, 49) == 0);
            bus.pop   = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
